// File: rtl/unit_converter_seq.sv
// Sequential unit converter: (data_in * MUL) / DIV via restoring divider.
// Ports: clk/rst_n, in_valid/in_ready/data_in/convert_to, out_valid/out_ready/data_out/rem_out/ovf.
module unit_converter_seq #(
  parameter int WIDTH = 19,
  parameter int MUL_W = 4,
  parameter int DIV_W = 7,
  parameter int DIV0  = 100,
  parameter int DIV2  = 30,
  parameter int MUL3  = 12,
  parameter int DIV3  = 30,
  parameter int ROUND = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       convert_to,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [DIV_W-1:0] rem_out,
  output logic             ovf
);

  localparam int DW = WIDTH + MUL_W;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0]    dvd;
  logic [DIV_W-1:0] dvs;
  logic [DIV_W:0]   rem;
  logic [CW-1:0]    cnt;

  logic             pass;
  logic             last;
  logic [MUL_W-1:0] mul_sel;
  logic [DIV_W-1:0] div_sel;
  logic [DW-1:0]    prod;

  logic [DIV_W+1:0] dvs_x;
  logic [DIV_W+1:0] rem_sh;
  logic [DIV_W+1:0] rem_nxt;
  logic             ge;
  logic [DW-1:0]    q_step;
  logic             round_up;
  logic [DW:0]      q_rnd;
  logic             sat;

  assign pass = (convert_to == 2'b01);
  assign last = (cnt == CW'(1));

  always_comb begin
    mul_sel = MUL_W'(1);
    div_sel = DIV_W'(DIV3);
    unique case (convert_to)
      2'b00: div_sel = DIV_W'(DIV0);
      2'b01: div_sel = DIV_W'(DIV3);
      2'b10: div_sel = DIV_W'(DIV2);
      2'b11: begin
        mul_sel = MUL_W'(MUL3);
        div_sel = DIV_W'(DIV3);
      end
    endcase
  end

  assign prod = DW'(data_in) * DW'(mul_sel);

  // One restoring step: shift in next dividend bit, subtract if it fits.
  assign dvs_x   = {2'b00, dvs};
  assign rem_sh  = {rem, dvd[DW-1]};
  assign ge      = (rem_sh >= dvs_x);
  assign rem_nxt = ge ? (rem_sh - dvs_x) : rem_sh;
  assign q_step  = {dvd[DW-2:0], ge};

  // Round half up: 2*rem >= divisor.
  assign round_up = (ROUND != 0) &&
                    ({rem_nxt, 1'b0} >= {1'b0, dvs_x});
  assign q_rnd    = {1'b0, q_step} + (DW+1)'(round_up);
  assign sat      = |q_rnd[DW:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = pass ? DONE : DIV;
      end
      DIV: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      cnt      <= '0;
      data_out <= '0;
      rem_out  <= '0;
      ovf      <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      if (pass) begin
        data_out <= data_in;
        rem_out  <= '0;
        ovf      <= 1'b0;
      end else begin
        dvd <= prod;
        dvs <= div_sel;
        rem <= '0;
        cnt <= CW'(DW);
      end
    end else if (state == DIV) begin
      dvd <= q_step;
      rem <= rem_nxt[DIV_W:0];
      cnt <= cnt - CW'(1);
      if (last) begin
        rem_out  <= rem_nxt[DIV_W-1:0];
        data_out <= sat ? '1 : q_rnd[WIDTH-1:0];
        ovf      <= sat;
      end
    end
  end

endmodule

// File: tb/tb_unit_converter_seq.sv
// Scoreboard bench for unit_converter_seq: three parameter sets driven in lockstep.
// Default, ROUND=1, and saturating (MUL3=15, DIV3=1) instances.
module tb_unit_converter_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [18:0] data_in;
  logic [1:0]  convert_to;
  logic        out_ready;

  logic        ir_d, ov_d, of_d;
  logic [18:0] do_d;
  logic [6:0]  ro_d;
  logic        ir_r, ov_r, of_r;
  logic [18:0] do_r;
  logic [6:0]  ro_r;
  logic        ir_o, ov_o, of_o;
  logic [18:0] do_o;
  logic [6:0]  ro_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [18:0] d;
    logic [6:0]  r;
    logic        o;
  } exp_t;

  exp_t qd[$];
  exp_t qr[$];
  exp_t qo[$];

  unit_converter_seq dut_d (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir_d),
    .data_in(data_in), .convert_to(convert_to),
    .out_valid(ov_d), .out_ready(out_ready),
    .data_out(do_d), .rem_out(ro_d), .ovf(of_d)
  );

  unit_converter_seq #(.ROUND(1)) dut_r (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir_r),
    .data_in(data_in), .convert_to(convert_to),
    .out_valid(ov_r), .out_ready(out_ready),
    .data_out(do_r), .rem_out(ro_r), .ovf(of_r)
  );

  unit_converter_seq #(.MUL3(15), .DIV3(1)) dut_o (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir_o),
    .data_in(data_in), .convert_to(convert_to),
    .out_valid(ov_o), .out_ready(out_ready),
    .data_out(do_o), .rem_out(ro_o), .ovf(of_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [18:0] d, input logic [1:0] m,
                                 input int mul3, input int div3,
                                 input bit rnd);
    exp_t e;
    longint p, q, r, dv, mul;
    if (m == 2'b01) begin
      e.d = d;
      e.r = '0;
      e.o = 1'b0;
      return e;
    end
    mul = (m == 2'b11) ? mul3 : 1;
    dv  = (m == 2'b00) ? 100 : (m == 2'b10) ? 30 : div3;
    p = longint'(d) * mul;
    q = p / dv;
    r = p % dv;
    if (rnd && 2 * r >= dv) q++;
    e.r = r[6:0];
    if (q > 524287) begin
      e.d = '1;
      e.o = 1'b1;
    end else begin
      e.d = q[18:0];
      e.o = 1'b0;
    end
    return e;
  endfunction

  // Entered and left at posedge+1 with all instances idle.
  task automatic run_req(input logic [18:0] d, input logic [1:0] m,
                         input int hold, input bit pulse, input bit early);
    exp_t ed, er, eo;
    int n;
    qd.push_back(model(d, m, 12, 30, 1'b0));
    qr.push_back(model(d, m, 12, 30, 1'b1));
    qo.push_back(model(d, m, 15, 1, 1'b0));
    out_ready  = early;
    in_valid   = 1'b1;
    data_in    = d;
    convert_to = m;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    data_in    = '0;
    convert_to = 2'b00;
    n = 0;
    while (!ov_d && n < 40) begin
      if (pulse && n == 4) begin
        in_valid   = 1'b1;
        data_in    = 19'd7;
        convert_to = 2'b01;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, (m == 2'b01) ? 0 : 23);
    chk("valid_r", ov_r, 1);
    chk("valid_o", ov_o, 1);
    ed = qd.pop_front();
    er = qr.pop_front();
    eo = qo.pop_front();
    chk("data_d", do_d, ed.d);
    chk("rem_d", ro_d, ed.r);
    chk("ovf_d", of_d, ed.o);
    chk("data_r", do_r, er.d);
    chk("rem_r", ro_r, er.r);
    chk("ovf_r", of_r, er.o);
    chk("data_o", do_o, eo.d);
    chk("rem_o", ro_o, eo.r);
    chk("ovf_o", of_o, eo.o);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", ov_d, 1);
      chk("hold_ready", ir_d, 0);
      chk("hold_data", do_d, ed.d);
      chk("hold_rem", ro_d, ed.r);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", ov_d, 0);
    chk("post_ready", ir_d, 1);
    if (pulse) begin
      repeat (30) @(posedge clk);
      #1;
      chk("single_result", ov_d, 0);
      chk("single_ready", ir_d, 1);
    end
  endtask

  task automatic run_reset_mid();
    in_valid   = 1'b1;
    data_in    = 19'd12345;
    convert_to = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", ov_d, 0);
    chk("rst_data", do_d, 0);
    chk("rst_rem", ro_d, 0);
    chk("rst_ovf_o", of_o, 0);
    chk("rst_ready", ir_d, 1);
    chk("rst_valid_r", ov_r, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    data_in    = '0;
    convert_to = 2'b00;
    out_ready  = 1'b0;
    #12;
    chk("reset_valid", ov_d, 0);
    chk("reset_ready", ir_d, 1);
    chk("reset_data", do_d, 0);
    chk("reset_rem", ro_d, 0);
    chk("reset_ovf", of_d, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req(19'd12345,  2'b00, 0, 1'b0, 1'b0);
    run_req(19'd12350,  2'b00, 0, 1'b0, 1'b0);
    run_req(19'd524287, 2'b01, 0, 1'b0, 1'b0);
    run_req(19'd59,     2'b10, 0, 1'b0, 1'b0);
    run_req(19'd100,    2'b11, 0, 1'b0, 1'b0);
    run_req(19'd524287, 2'b11, 0, 1'b0, 1'b0);
    run_req(19'd1000,   2'b11, 0, 1'b0, 1'b0);
    run_req(19'd0,      2'b00, 0, 1'b0, 1'b0);
    run_req(19'd99,     2'b00, 0, 1'b0, 1'b0);
    run_req(19'd4321,   2'b10, 10, 1'b1, 1'b0);
    run_req(19'd777,    2'b01, 0, 1'b0, 1'b1);
    run_req(19'd31415,  2'b11, 0, 1'b0, 1'b1);
    run_reset_mid();
    run_req(19'd12345,  2'b00, 0, 1'b0, 1'b0);
    run_req(19'd89,     2'b01, 3, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
